// File: rtl/data_mem_pkg.sv
// Shared types for the data memory controller.
//   size_e  : access size encoding carried on req_size
//   state_e : controller FSM states
//   byte_en : 4-bit lane enable for a store, from size and addr[1:0]
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Little-endian lane enables; lane 0 is bits [7:0].
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and extension.
//   word_i : 32-bit word read from the array
//   addr_i : byte offset within the word
//   size_i : access size (byte/half/word)
//   uns_i  : 1 = zero-extend, 0 = sign-extend
//   data_o : right-aligned, extended load result
module mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word_i >> {addr_i, 3'b000});
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed MIPS32 data memory with valid/ready request handshake and
// a fixed read latency modelling a synchronous SRAM.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : request present          req_ready : can accept this cycle
//   req_we      : 1 store / 0 load         req_size  : 00 b, 01 h, 10 w, 11 rsvd
//   req_uns     : zero-extend loads        req_addr  : byte address
//   req_wdata   : right-aligned store data
//   resp_valid  : one-cycle response pulse
//   resp_rdata  : extended load data (0 for stores/errors), held until next response
//   resp_err    : misaligned, out-of-range or reserved size
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned     IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [1:0]       lane_q;
  size_e            size_q;
  logic             uns_q;
  logic [IDX_W-1:0] idx_q;

  size_e            req_sz;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             accept;
  logic [3:0]       be;
  logic [31:0]      wlanes;

  logic             in_idle;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_lane;
  size_e            rd_size;
  logic             rd_uns;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;

  assign req_sz  = size_e'(req_size);
  assign req_idx = req_addr[IDX_W+1:2];
  assign in_idle = (state_q == IDLE);

  // Accept is suppressed while rst is high so a store coincident with
  // reset assertion never reaches the array.
  assign req_ready = in_idle;
  assign accept    = req_valid & in_idle & ~rst;

  always_comb begin
    req_err = 1'b0;
    case (req_sz)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      SZ_RSVD: req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= LIMIT) req_err = 1'b1;
  end

  // Replicate store data across lanes; the byte enables pick the live ones.
  always_comb begin
    be = byte_en(req_sz, req_addr[1:0]);
    case (req_sz)
      SZ_BYTE: wlanes = {4{req_wdata[7:0]}};
      SZ_HALF: wlanes = {2{req_wdata[15:0]}};
      default: wlanes = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int unsigned lane = 0; lane < 4; lane++) begin
        if (be[lane]) mem[req_idx][8*lane +: 8] <= wlanes[8*lane +: 8];
      end
    end
  end

  // With RD_LAT=1 the read happens at the accept edge, so the live request
  // fields drive the read path in IDLE; otherwise the captured ones do.
  always_comb begin
    rd_idx  = in_idle ? req_idx       : idx_q;
    rd_lane = in_idle ? req_addr[1:0] : lane_q;
    rd_size = in_idle ? req_sz        : size_q;
    rd_uns  = in_idle ? req_uns       : uns_q;
  end

  assign rd_word = mem[rd_idx];

  mem_load_align u_align (
    .word_i (rd_word),
    .addr_i (rd_lane),
    .size_i (rd_size),
    .uns_i  (rd_uns),
    .data_o (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_we) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else if (RD_LAT == 1) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = load_data;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(RD_LAT - 1);
          end
        end
      end
      WAIT: begin
        // Only good loads wait; the final decrement edge performs the read.
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = load_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      lane_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        lane_q <= req_addr[1:0];
        size_q <= req_sz;
        uns_q  <= req_uns;
        idx_q  <= req_idx;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b10;
  logic              req_uns = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_uns    (req_uns),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // One request: waits for ready, returns response fields, latency in
  // cycles from accept edge (-1 on timeout) and whether ready rose while busy.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output logic busy_rdy);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy_rdy = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      if (req_ready) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (req_ready) busy_rdy = 1'b1;
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rd=%h err=%b want rdy=1 vld=0 rd=0 err=0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, busy; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, busy);
    n_cmp++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_resp: got lat=%0d rd=%h err=%b want lat=1 rd=0 err=0", lat, rd, er);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, busy);
    n_cmp++;
    if (lat !== RD_LAT || rd !== 32'hDEADBEEF || er !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_10: got lat=%0d rd=%h err=%b busy_rdy=%b want lat=%0d rd=deadbeef err=0 busy_rdy=0",
               lat, rd, er, busy, RD_LAT);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL after_pulse: got vld=%b rdy=%b rd=%h want vld=0 rdy=1 rd=deadbeef",
               resp_valid, req_ready, resp_rdata);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er, busy; int lat;
    logic [31:0] a_tab [8] = '{32'h11, 32'h11, 32'h10, 32'h13, 32'h12, 32'h22, 32'h20, 32'h22};
    logic [1:0]  s_tab [8] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic        u_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_tab [8] = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'hFFFFFFDE,
                               32'hFFFFDEAD, 32'h00001234, 32'h0000F00D, 32'h00001234};
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF80, rd, er, lat, busy);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat, busy);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h55551234, rd, er, lat, busy);
    n_cmp++;
    if (lat !== 1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_resp: got lat=%0d err=%b want lat=1 err=0", lat, er);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, s_tab[i], u_tab[i], a_tab[i], 32'h0, rd, er, lat, busy);
      n_cmp++;
      if (rd !== e_tab[i] || er !== 1'b0 || lat !== RD_LAT) begin
        n_fail++;
        $display("FAIL load_%0d @%h: got rd=%h err=%b lat=%0d want rd=%h err=0 lat=%0d",
                 i, a_tab[i], rd, er, lat, e_tab[i], RD_LAT);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, busy; int lat;
    logic        w_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  s_tab [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [31:0] a_tab [6] = '{32'h13, 32'h21, 32'h20, 32'h1000, 32'h1020, 32'h2000};
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h11112222, rd, er, lat, busy);
    for (int i = 0; i < 6; i++) begin
      do_req(w_tab[i], s_tab[i], 1'b0, a_tab[i], 32'hBAD0BAD0, rd, er, lat, busy);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
        n_fail++;
        $display("FAIL err_%0d @%h: got err=%b rd=%h lat=%0d want err=1 rd=0 lat=1",
                 i, a_tab[i], er, rd, lat);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, busy);
    n_cmp++;
    if (rd !== 32'h1234F00D || er !== 1'b0) begin
      n_fail++;
      $display("FAIL no_corrupt_20: got rd=%h err=%b want rd=1234f00d err=0", rd, er);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat, busy);
    n_cmp++;
    if (rd !== 32'h11112222 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL no_corrupt_00: got rd=%h err=%b want rd=11112222 err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, busy; int lat;
    logic [31:0] e_tab [3] = '{32'h01020304, 32'hA5A55A5A, 32'h7FFF8000};
    int acc_cyc [3];
    logic [31:0] got [3];
    int idx, nresp;
    logic rdy;
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4*i), e_tab[i], rd, er, lat, busy);
    idx = 0; nresp = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (idx < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 32'h40 + 32'(4*idx);
      end else begin
        req_valid = 1'b0;
      end
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      #1;
      if (resp_valid) begin
        if (nresp < 3) got[nresp] = resp_rdata;
        nresp++;
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (idx !== 3 || nresp !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got accepts=%0d resps=%0d want 3 and 3", idx, nresp);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (acc_cyc[i] - acc_cyc[i-1] !== RD_LAT + 1) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], RD_LAT + 1);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== e_tab[i]) begin
          n_fail++;
          $display("FAIL b2b_data_%0d: got %h want %h", i, got[i], e_tab[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, busy; int lat;
    int guard, pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h10;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got rdy=%b vld=%b rd=%h err=%b want rdy=1 vld=0 rd=0 err=0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got pulses=%0d rdy=%b want pulses=0 rdy=1", pulses, req_ready);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, busy);
    n_cmp++;
    if (rd !== 32'hDEAD80EF || er !== 1'b0 || lat !== RD_LAT) begin
      n_fail++;
      $display("FAIL rst_mid_persist: got rd=%h err=%b lat=%0d want rd=dead80ef err=0 lat=%0d",
               rd, er, lat, RD_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
